// File: rtl/wb_load_store_unit.sv
// Wishbone B4 classic load/store master: byte-lane steering, load extension,
// two-beat splitting of word-crossing accesses, retry and timeout handling.
module wb_load_store_unit #(
    parameter int SPLIT_MISALIGNED = 1,
    parameter int MAX_RETRY        = 3,
    parameter int TIMEOUT          = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] adr_o,
    output logic [3:0]  sel_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic        rty_i
);
    typedef enum logic [2:0] {IDLE, BEAT1, BEAT2, RETRY, RESP} state_t;

    localparam logic [7:0] MAX_RETRY_L = 8'(MAX_RETRY);
    localparam logic [7:0] TIMEOUT_L   = 8'(TIMEOUT);

    state_t      state_reg, state_next;
    logic        we_reg, second_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] addr_reg, wdata_reg;
    logic [31:0] data_reg, data_next;
    logic [7:0]  retry_reg, retry_next, timer_reg, timer_next;
    logic [31:0] rsp_rdata_reg, rsp_rdata_next;
    logic        rsp_err_reg, rsp_err_next;
    logic        capture, finish, finish_err;

    function automatic logic [3:0] lane_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic crosses(input logic [1:0] off, input logic [1:0] sz);
        logic [2:0] nbytes;
        nbytes = (sz == 2'b00) ? 3'd1 : (sz == 2'b01) ? 3'd2 : 3'd4;
        return ({2'b00, off} + {1'b0, nbytes}) > 4'd4;
    endfunction

    function automatic logic legal(input logic we, input logic [2:0] f3);
        if (we)
            return !f3[2] && (f3[1:0] != 2'b11);
        return (f3[1:0] != 2'b11) && (f3 != 3'b110);
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [1:0] off);
        logic [63:0] d;
        d = {x, x} << {off, 3'b000};
        return d[63:32];
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input logic [1:0] off);
        logic [63:0] d;
        d = {x, x} >> {off, 3'b000};
        return d[31:0];
    endfunction

    logic [1:0]  off;
    logic [7:0]  lanes_wide;
    logic        split;
    logic        beat;
    logic [31:0] base_adr, merged, aligned, load_result;

    assign off        = addr_reg[1:0];
    assign lanes_wide = {4'b0000, lane_mask(funct3_reg[1:0])} << off;
    assign split      = crosses(off, funct3_reg[1:0]);
    assign beat       = (state_reg == BEAT1) || (state_reg == BEAT2);
    assign base_adr   = {addr_reg[31:2], 2'b00};

    assign req_ready_o = (state_reg == IDLE);
    assign rsp_valid_o = (state_reg == RESP);
    assign rsp_rdata_o = rsp_rdata_reg;
    assign rsp_err_o   = rsp_err_reg;
    assign cyc_o       = beat;
    assign stb_o       = beat;
    assign we_o        = beat && we_reg;
    assign adr_o       = !beat ? 32'd0 : (state_reg == BEAT2) ? base_adr + 32'd4 : base_adr;
    assign sel_o       = !beat ? 4'b0000 : (state_reg == BEAT2) ? lanes_wide[7:4] : lanes_wide[3:0];
    assign dat_o       = beat ? rotl(wdata_reg, off) : 32'd0;

    // Each beat owns a disjoint set of lanes, so both beats merge into one word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[8*gi +: 8] = sel_o[gi] ? dat_i[8*gi +: 8] : data_reg[8*gi +: 8];
        end
    endgenerate

    assign aligned = rotr(merged, off);

    always_comb begin
        case (funct3_reg)
            3'b000:  load_result = {{24{aligned[7]}}, aligned[7:0]};
            3'b001:  load_result = {{16{aligned[15]}}, aligned[15:0]};
            3'b100:  load_result = {24'd0, aligned[7:0]};
            3'b101:  load_result = {16'd0, aligned[15:0]};
            default: load_result = aligned;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        data_next      = data_reg;
        retry_next     = retry_reg;
        timer_next     = timer_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;
        capture        = 1'b0;
        finish         = 1'b0;
        finish_err     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid_i) begin
                    capture    = 1'b1;
                    data_next  = 32'd0;
                    retry_next = 8'd0;
                    timer_next = 8'd0;
                    if (!legal(req_we_i, req_funct3_i) ||
                        (SPLIT_MISALIGNED == 0 && crosses(req_addr_i[1:0], req_funct3_i[1:0]))) begin
                        finish     = 1'b1;
                        finish_err = 1'b1;
                    end else begin
                        state_next = BEAT1;
                    end
                end
            end
            BEAT1, BEAT2: begin
                if (err_i) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else if (rty_i) begin
                    if (retry_reg >= MAX_RETRY_L) begin
                        finish     = 1'b1;
                        finish_err = 1'b1;
                    end else begin
                        retry_next = retry_reg + 8'd1;
                        state_next = RETRY;
                    end
                end else if (ack_i) begin
                    data_next = merged;
                    if (state_reg == BEAT1 && split) begin
                        state_next = BEAT2;
                        retry_next = 8'd0;
                        timer_next = 8'd0;
                    end else begin
                        finish = 1'b1;
                    end
                end else if (TIMEOUT != 0 && timer_reg == TIMEOUT_L - 8'd1) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else begin
                    timer_next = timer_reg + 8'd1;
                end
            end
            RETRY: begin
                state_next = second_reg ? BEAT2 : BEAT1;
                timer_next = 8'd0;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (finish) begin
            state_next     = RESP;
            rsp_err_next   = finish_err;
            rsp_rdata_next = (finish_err || we_reg) ? 32'd0 : load_result;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            we_reg        <= 1'b0;
            second_reg    <= 1'b0;
            funct3_reg    <= 3'd0;
            addr_reg      <= 32'd0;
            wdata_reg     <= 32'd0;
            data_reg      <= 32'd0;
            retry_reg     <= 8'd0;
            timer_reg     <= 8'd0;
            rsp_rdata_reg <= 32'd0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            data_reg      <= data_next;
            retry_reg     <= retry_next;
            timer_reg     <= timer_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
            if (capture) begin
                we_reg     <= req_we_i;
                funct3_reg <= req_funct3_i;
                addr_reg   <= req_addr_i;
                wdata_reg  <= req_wdata_i;
                second_reg <= 1'b0;
            end else if (state_reg == BEAT2) begin
                second_reg <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wb_load_store_unit.sv
// Directed bench for wb_load_store_unit: vector table of single/split accesses
// plus hand sequences for retry, timeout, bus error, reset abort and no-split mode.
module tb_wb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0, req_we_i = 1'b0;
    logic [2:0]  req_funct3_i = 3'd0;
    logic [31:0] req_addr_i = 32'd0, req_wdata_i = 32'd0;
    logic        req_ready_o, rsp_valid_o, rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic        cyc_o, stb_o, we_o;
    logic [31:0] adr_o, dat_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i = 32'd0;
    logic        ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0;

    // second instance without splitting; its bus is never answered
    logic        z_req_valid = 1'b0, z_req_we = 1'b0;
    logic [2:0]  z_req_funct3 = 3'd0;
    logic [31:0] z_req_addr = 32'd0, z_req_wdata = 32'd0;
    logic        z_req_ready, z_rsp_valid, z_rsp_err, z_cyc, z_stb, z_we;
    logic [31:0] z_rsp_rdata, z_adr, z_dat_o;
    logic [3:0]  z_sel;
    logic [31:0] z_dat_i = 32'd0;
    logic        z_ack = 1'b0, z_err = 1'b0, z_rty = 1'b0;

    always #5 clk = ~clk;

    wb_load_store_unit dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .sel_o(sel_o),
        .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
    );

    wb_load_store_unit #(.SPLIT_MISALIGNED(0)) dut_nosplit (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(z_req_valid), .req_ready_o(z_req_ready), .req_we_i(z_req_we),
        .req_funct3_i(z_req_funct3), .req_addr_i(z_req_addr), .req_wdata_i(z_req_wdata),
        .rsp_valid_o(z_rsp_valid), .rsp_rdata_o(z_rsp_rdata), .rsp_err_o(z_rsp_err),
        .cyc_o(z_cyc), .stb_o(z_stb), .we_o(z_we), .adr_o(z_adr), .sel_o(z_sel),
        .dat_o(z_dat_o), .dat_i(z_dat_i), .ack_i(z_ack), .err_i(z_err), .rty_i(z_rty)
    );

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // slave model state and per-transaction observations
    logic [31:0] mem0, mem1;
    logic [31:0] r_adr [8];
    logic [3:0]  r_sel [8];
    logic [31:0] r_dat [8];
    logic        r_we  [8];
    int          r_issues, r_lat;
    logic        r_got, r_err, r_ready0, r_cyc_rsp;
    logic [31:0] r_rdata;
    logic        p_ready, p_valid;
    logic [31:0] p_rdata;

    // mode 0: ack after `waits` cycles; 1: rty `rty_n` times then ack; 2: silent; 3: err
    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int waits, input int mode,
                       input int rty_n, input int limit);
        int stb_run;
        int rty_left;
        logic [31:0] a1;
        a1 = {addr[31:2], 2'b00};
        stb_run = 0; rty_left = rty_n;
        r_issues = 0; r_lat = 0; r_got = 1'b0; r_err = 1'b0; r_rdata = 32'd0; r_cyc_rsp = 1'b0;
        @(negedge clk);
        r_ready0 = req_ready_o;
        req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3;
        req_addr_i = addr; req_wdata_i = wdata;
        @(posedge clk);
        for (int c = 0; c < limit && !r_got; c++) begin
            @(negedge clk);
            r_lat++;
            req_valid_i = 1'b0;
            ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
            if (rsp_valid_o) begin
                r_got = 1'b1; r_rdata = rsp_rdata_o; r_err = rsp_err_o; r_cyc_rsp = cyc_o;
            end else if (stb_o) begin
                if (stb_run == 0) begin
                    r_adr[r_issues & 7] = adr_o; r_sel[r_issues & 7] = sel_o;
                    r_dat[r_issues & 7] = dat_o; r_we[r_issues & 7] = we_o;
                    r_issues++;
                end
                stb_run++;
                dat_i = (adr_o == a1) ? mem0 : mem1;
                if (mode == 3) begin
                    err_i = 1'b1;
                end else if (mode == 1 && rty_left > 0) begin
                    rty_i = 1'b1; rty_left--; stb_run = 0;
                end else if ((mode == 0 && stb_run > waits) || mode == 1) begin
                    ack_i = 1'b1; stb_run = 0;
                    for (int l = 0; l < 4; l++)
                        if (we_o && sel_o[l]) begin
                            if (adr_o == a1) mem0[8*l +: 8] = dat_o[8*l +: 8];
                            else             mem1[8*l +: 8] = dat_o[8*l +: 8];
                        end
                end
            end else begin
                stb_run = 0;
            end
        end
        if (!r_got) chk("response_bound", 32'd0, 32'd1);
        @(negedge clk);
        p_ready = req_ready_o; p_valid = rsp_valid_o; p_rdata = rsp_rdata_o;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata;
        int          waits;
        logic [31:0] w0, w1;
        int          beats;
        logic [3:0]  sel1, sel2;
        logic [31:0] dat1, rdata;
        logic        err;
        int          lat;
        logic [31:0] ew0, ew1;
    } vec_t;

    vec_t vecs [14];

    initial begin
        //            we    f3      addr          wdata         wt w0            w1            bt sel1     sel2     dat1          rdata         er lat ew0           ew1
        vecs[0]  = '{1'b0, 3'b010, 32'h2000_0000, 32'h0,        0, 32'h8382_8180, 32'h0,        1, 4'b1111, 4'b0000, 32'h0,        32'h8382_8180, 1'b0, 2, 32'h8382_8180, 32'h0};
        vecs[1]  = '{1'b0, 3'b000, 32'h2000_0002, 32'h0,        0, 32'h8382_8180, 32'h0,        1, 4'b0100, 4'b0000, 32'h0,        32'hFFFF_FF82, 1'b0, 2, 32'h8382_8180, 32'h0};
        vecs[2]  = '{1'b0, 3'b100, 32'h2000_0002, 32'h0,        0, 32'h8382_8180, 32'h0,        1, 4'b0100, 4'b0000, 32'h0,        32'h0000_0082, 1'b0, 2, 32'h8382_8180, 32'h0};
        vecs[3]  = '{1'b0, 3'b010, 32'h2000_0003, 32'h0,        0, 32'h1122_3344, 32'h5566_7788, 2, 4'b1000, 4'b0111, 32'h0,        32'h6677_8811, 1'b0, 3, 32'h1122_3344, 32'h5566_7788};
        vecs[4]  = '{1'b1, 3'b001, 32'h2000_0002, 32'hF3F2_F1F0, 0, 32'hDEAD_BEEF, 32'h0,        1, 4'b1100, 4'b0000, 32'hF1F0_F3F2, 32'h0,        1'b0, 2, 32'hF1F0_BEEF, 32'h0};
        vecs[5]  = '{1'b0, 3'b001, 32'h2000_0001, 32'h0,        0, 32'h8382_8180, 32'h0,        1, 4'b0110, 4'b0000, 32'h0,        32'hFFFF_8281, 1'b0, 2, 32'h8382_8180, 32'h0};
        vecs[6]  = '{1'b0, 3'b101, 32'h2000_0003, 32'h0,        0, 32'h1122_3344, 32'h5566_7788, 2, 4'b1000, 4'b0001, 32'h0,        32'h0000_8811, 1'b0, 3, 32'h1122_3344, 32'h5566_7788};
        vecs[7]  = '{1'b0, 3'b011, 32'h2000_0000, 32'h0,        0, 32'h1234_5678, 32'h0,        0, 4'b0000, 4'b0000, 32'h0,        32'h0,        1'b1, 1, 32'h1234_5678, 32'h0};
        vecs[8]  = '{1'b1, 3'b011, 32'h2000_0000, 32'hFFFF_FFFF, 0, 32'h1234_5678, 32'h0,        0, 4'b0000, 4'b0000, 32'h0,        32'h0,        1'b1, 1, 32'h1234_5678, 32'h0};
        vecs[9]  = '{1'b1, 3'b010, 32'h2000_0001, 32'hA1B2_C3D4, 0, 32'h0,        32'h0,        2, 4'b1110, 4'b0001, 32'hB2C3_D4A1, 32'h0,        1'b0, 3, 32'hB2C3_D400, 32'h0000_00A1};
        vecs[10] = '{1'b0, 3'b010, 32'h2000_0008, 32'h0,        2, 32'hCAFE_F00D, 32'h0,        1, 4'b1111, 4'b0000, 32'h0,        32'hCAFE_F00D, 1'b0, 4, 32'hCAFE_F00D, 32'h0};
        vecs[11] = '{1'b0, 3'b000, 32'h2000_0003, 32'h0,        0, 32'h7F00_0000, 32'h0,        1, 4'b1000, 4'b0000, 32'h0,        32'h0000_007F, 1'b0, 2, 32'h7F00_0000, 32'h0};
        vecs[12] = '{1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0,        0, 32'hAABB_CCDD, 32'h1122_3344, 2, 4'b1100, 4'b0011, 32'h0,        32'h3344_AABB, 1'b0, 3, 32'hAABB_CCDD, 32'h1122_3344};
        vecs[13] = '{1'b1, 3'b000, 32'h2000_0001, 32'h0000_00E5, 0, 32'h4433_2211, 32'h0,        1, 4'b0010, 4'b0000, 32'h0000_E500, 32'h0,        1'b0, 2, 32'h4433_E511, 32'h0};

        // reset state
        #2;
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_cyc_stb_we", {29'd0, cyc_o, stb_o, we_o}, 32'd0);
        chk("rst_adr_sel", adr_o | {28'd0, sel_o}, 32'd0);
        chk("rst_rsp", rsp_rdata_o | {30'd0, rsp_valid_o, rsp_err_o}, 32'd0);
        @(negedge clk); rst_i = 1'b0;

        for (int i = 0; i < 14; i++) begin
            logic [31:0] a1;
            a1 = {vecs[i].addr[31:2], 2'b00};
            mem0 = vecs[i].w0; mem1 = vecs[i].w1;
            run(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].waits, 0, 0, 50);
            $display("txn %0d: we=%b f3=%b addr=%h rdata=%h err=%b lat=%0d beats=%0d",
                     i, vecs[i].we, vecs[i].f3, vecs[i].addr, r_rdata, r_err, r_lat, r_issues);
            chk($sformatf("v%0d_ready", i), 32'(r_ready0), 32'd1);
            chk($sformatf("v%0d_beats", i), 32'(r_issues), 32'(vecs[i].beats));
            if (vecs[i].beats >= 1) begin
                chk($sformatf("v%0d_adr1", i), r_adr[0], a1);
                chk($sformatf("v%0d_sel1", i), 32'(r_sel[0]), 32'(vecs[i].sel1));
                chk($sformatf("v%0d_dat1", i), r_dat[0], vecs[i].dat1);
                chk($sformatf("v%0d_we1", i), 32'(r_we[0]), 32'(vecs[i].we));
            end
            if (vecs[i].beats == 2) begin
                chk($sformatf("v%0d_adr2", i), r_adr[1], a1 + 32'd4);
                chk($sformatf("v%0d_sel2", i), 32'(r_sel[1]), 32'(vecs[i].sel2));
                chk($sformatf("v%0d_dat2", i), r_dat[1], vecs[i].dat1);
            end
            chk($sformatf("v%0d_rdata", i), r_rdata, vecs[i].rdata);
            chk($sformatf("v%0d_err", i), 32'(r_err), 32'(vecs[i].err));
            chk($sformatf("v%0d_lat", i), 32'(r_lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_cyc_in_resp", i), 32'(r_cyc_rsp), 32'd0);
            chk($sformatf("v%0d_mem0", i), mem0, vecs[i].ew0);
            chk($sformatf("v%0d_mem1", i), mem1, vecs[i].ew1);
            chk($sformatf("v%0d_post_ready", i), 32'(p_ready), 32'd1);
            chk($sformatf("v%0d_post_valid", i), 32'(p_valid), 32'd0);
            chk($sformatf("v%0d_rdata_hold", i), p_rdata, vecs[i].rdata);
        end

        // retries exhausted: 4 issues separated by idle gaps, then error
        mem0 = 32'h0BAD_F00D; mem1 = 32'h0;
        run(1'b0, 3'b010, 32'h2000_0010, 32'h0, 0, 1, 99, 50);
        $display("txn retry_exhaust: issues=%0d err=%b lat=%0d", r_issues, r_err, r_lat);
        chk("rty4_issues", 32'(r_issues), 32'd4);
        chk("rty4_lat", 32'(r_lat), 32'd8);
        chk("rty4_err", 32'(r_err), 32'd1);
        chk("rty4_rdata", r_rdata, 32'd0);

        // two retries then success
        run(1'b0, 3'b010, 32'h2000_0010, 32'h0, 0, 1, 2, 50);
        $display("txn retry_ok: issues=%0d err=%b lat=%0d rdata=%h", r_issues, r_err, r_lat, r_rdata);
        chk("rty2_issues", 32'(r_issues), 32'd3);
        chk("rty2_lat", 32'(r_lat), 32'd6);
        chk("rty2_err", 32'(r_err), 32'd0);
        chk("rty2_rdata", r_rdata, 32'h0BAD_F00D);
        chk("rty2_adr", r_adr[2], 32'h2000_0010);

        // silent slave: timeout after 255 strobe cycles
        run(1'b0, 3'b010, 32'h2000_0020, 32'h0, 0, 2, 0, 400);
        $display("txn timeout: issues=%0d err=%b lat=%0d", r_issues, r_err, r_lat);
        chk("tmo_issues", 32'(r_issues), 32'd1);
        chk("tmo_lat", 32'(r_lat), 32'd256);
        chk("tmo_err", 32'(r_err), 32'd1);
        chk("tmo_cyc", 32'(r_cyc_rsp), 32'd0);

        // bus error on first beat of a split store skips the second beat
        mem0 = 32'h0; mem1 = 32'h0;
        run(1'b1, 3'b010, 32'h2000_0002, 32'h1234_5678, 0, 3, 0, 50);
        $display("txn split_err: issues=%0d err=%b lat=%0d", r_issues, r_err, r_lat);
        chk("berr_issues", 32'(r_issues), 32'd1);
        chk("berr_lat", 32'(r_lat), 32'd2);
        chk("berr_err", 32'(r_err), 32'd1);

        // asynchronous reset in the middle of a beat
        begin
            int seen;
            @(negedge clk);
            req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010; req_addr_i = 32'h2000_0030;
            @(posedge clk);
            @(negedge clk);
            req_valid_i = 1'b0;
            chk("abort_cyc_before", 32'(cyc_o), 32'd1);
            #2 rst_i = 1'b1;
            #1;
            chk("abort_cyc_now", {30'd0, cyc_o, stb_o}, 32'd0);
            chk("abort_ready", 32'(req_ready_o), 32'd1);
            @(negedge clk); rst_i = 1'b0;
            seen = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (rsp_valid_o) seen++;
            end
            $display("txn reset_abort: responses=%0d", seen);
            chk("abort_no_rsp", 32'(seen), 32'd0);
            chk("abort_idle_ready", 32'(req_ready_o), 32'd1);
        end

        // no-split instance: crossing access is rejected without a bus cycle
        begin
            int lat;
            logic cyc_seen, got, err;
            lat = 0; cyc_seen = 1'b0; got = 1'b0; err = 1'b0;
            @(negedge clk);
            z_req_valid = 1'b1; z_req_we = 1'b0; z_req_funct3 = 3'b010; z_req_addr = 32'h2000_0003;
            @(posedge clk);
            for (int c = 0; c < 8 && !got; c++) begin
                @(negedge clk);
                z_req_valid = 1'b0;
                lat++;
                if (z_cyc) cyc_seen = 1'b1;
                if (z_rsp_valid) begin got = 1'b1; err = z_rsp_err; end
            end
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (z_cyc) cyc_seen = 1'b1;
            end
            $display("txn nosplit: got=%b err=%b lat=%0d cyc_seen=%b", got, err, lat, cyc_seen);
            chk("nosplit_got", 32'(got), 32'd1);
            chk("nosplit_err", 32'(err), 32'd1);
            chk("nosplit_lat", 32'(lat), 32'd1);
            chk("nosplit_cyc", 32'(cyc_seen), 32'd0);
            chk("nosplit_rdata", z_rsp_rdata, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
